vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; next generation of the team's fixed 640x480 controller.
- All porch, border and active widths are parameters, sync polarity is selectable, and border colour is fixed by parameter.
- Issues pixel requests REQ_LEAD cycles ahead of display, so an external registered ROM/RAM/pattern source returns pixel colour aligned with sync and data-enable.
- Sits between the pixel-clock domain and the picture source, and drives the VGA connector/DAC.

---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, display-pipeline control bundle and counter-width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, with 8-pixel/8-line borders
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 40;
    localparam int VGA640_H_LEFT   = 8;
    localparam int VGA640_H_VALID  = 640;
    localparam int VGA640_H_RIGHT  = 8;
    localparam int VGA640_H_FRONT  = 8;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 25;
    localparam int VGA640_V_TOP    = 8;
    localparam int VGA640_V_VALID  = 480;
    localparam int VGA640_V_BOTTOM = 8;
    localparam int VGA640_V_FRONT  = 2;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, no borders
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BACK   = 88;
    localparam int SVGA800_H_LEFT   = 0;
    localparam int SVGA800_H_VALID  = 800;
    localparam int SVGA800_H_RIGHT  = 0;
    localparam int SVGA800_H_FRONT  = 40;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BACK   = 23;
    localparam int SVGA800_V_TOP    = 0;
    localparam int SVGA800_V_VALID  = 600;
    localparam int SVGA800_V_BOTTOM = 0;
    localparam int SVGA800_V_FRONT  = 1;

    // Per-pixel control flags carried from the request stage to the display stage
    typedef struct packed {
        logic hs;    // inside horizontal sync
        logic vs;    // inside vertical sync
        logic act;   // active picture pixel
        logic bord;  // border pixel (inside border rectangle, not active)
        logic h0;    // first clock of a line
        logic f0;    // first clock of a frame
    } disp_ctl_t;

    localparam int DISP_CTL_W = $bits(disp_ctl_t);

    // Counter width able to hold 0..max(a,b)-1; never narrower than one bit
    function automatic int calc_cw(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Generic W-bit x DEPTH-stage shift register with synchronous active-low clear.
// Latency: exactly DEPTH clocks from i_dat to o_dat.
// Backpressure: none; shifts every clock.
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    logic [W-1:0] r_stage [DEPTH];

    // Shift one stage per clock; clear flushes every stage to zero
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel requests lead display sync/de/colour by REQ_LEAD clocks.
// Latency: display outputs lag the raster counters by exactly REQ_LEAD clocks (REQ_LEAD 1..4).
// Backpressure: none; the picture source must return colour exactly REQ_LEAD clocks after pix_req.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BACK   = VGA640_H_BACK,
    parameter int H_LEFT   = VGA640_H_LEFT,
    parameter int H_VALID  = VGA640_H_VALID,
    parameter int H_RIGHT  = VGA640_H_RIGHT,
    parameter int H_FRONT  = VGA640_H_FRONT,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BACK   = VGA640_V_BACK,
    parameter int V_TOP    = VGA640_V_TOP,
    parameter int V_VALID  = VGA640_V_VALID,
    parameter int V_BOTTOM = VGA640_V_BOTTOM,
    parameter int V_FRONT  = VGA640_V_FRONT,
    parameter int COLOR_W  = 16,
    parameter int REQ_LEAD = 1,
    parameter logic SYNC_POL = 1'b1,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = '0,
    localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT,
    localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT,
    localparam int CW      = calc_cw(H_TOTAL, V_TOTAL)
) (
    input  logic               Clk_int,
    input  logic               Sys_Rst_n,
    input  logic [COLOR_W-1:0] pix_colour,
    output logic               pix_req,
    output logic [CW-1:0]      pix_x,
    output logic [CW-1:0]      pix_y,
    output logic [COLOR_W-1:0] Rgb,
    output logic               H_sys,
    output logic               V_sys,
    output logic               de,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_ACT0 = H_SYNC + H_BACK + H_LEFT;
    localparam int V_ACT0 = V_SYNC + V_BACK + V_TOP;

    // Region bounds are one bit wider than the counters: an exclusive upper
    // bound can equal H_TOTAL/V_TOTAL, which may be exactly 2**CW.
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] H_SYNC_HI = CW1'(H_SYNC);
    localparam logic [CW:0] H_BRD_LO  = CW1'(H_SYNC + H_BACK);
    localparam logic [CW:0] H_ACT_LO  = CW1'(H_ACT0);
    localparam logic [CW:0] H_ACT_HI  = CW1'(H_ACT0 + H_VALID);
    localparam logic [CW:0] H_BRD_HI  = CW1'(H_ACT0 + H_VALID + H_RIGHT);
    localparam logic [CW:0] V_SYNC_HI = CW1'(V_SYNC);
    localparam logic [CW:0] V_BRD_LO  = CW1'(V_SYNC + V_BACK);
    localparam logic [CW:0] V_ACT_LO  = CW1'(V_ACT0);
    localparam logic [CW:0] V_ACT_HI  = CW1'(V_ACT0 + V_VALID);
    localparam logic [CW:0] V_BRD_HI  = CW1'(V_ACT0 + V_VALID + V_BOTTOM);

    localparam logic [CW-1:0] H_MAX = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX = CW'(V_TOTAL - 1);

    logic [CW-1:0] r_cnt_h;
    logic [CW-1:0] r_cnt_v;

    logic [CW:0] w_h_ext;
    logic [CW:0] w_v_ext;
    logic        w_act;
    logic        w_bord;
    disp_ctl_t   w_ctl_req;
    disp_ctl_t   w_ctl_disp;

    // Raster counters: horizontal wraps every line, vertical steps at end of line
    always_ff @(posedge Clk_int) begin
        if (!Sys_Rst_n) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else if (r_cnt_h == H_MAX) begin
            r_cnt_h <= '0;
            r_cnt_v <= (r_cnt_v == V_MAX) ? '0 : r_cnt_v + 1'b1;
        end else begin
            r_cnt_h <= r_cnt_h + 1'b1;
        end
    end

    // Request stage: decoded straight from the counters
    assign w_h_ext = {1'b0, r_cnt_h};
    assign w_v_ext = {1'b0, r_cnt_v};

    assign w_act  = (w_h_ext >= H_ACT_LO) && (w_h_ext < H_ACT_HI) &&
                    (w_v_ext >= V_ACT_LO) && (w_v_ext < V_ACT_HI);
    assign w_bord = (w_h_ext >= H_BRD_LO) && (w_h_ext < H_BRD_HI) &&
                    (w_v_ext >= V_BRD_LO) && (w_v_ext < V_BRD_HI) && !w_act;

    assign pix_req = w_act;
    assign pix_x   = w_act ? (r_cnt_h - CW'(H_ACT0)) : '0;
    assign pix_y   = w_act ? (r_cnt_v - CW'(V_ACT0)) : '0;

    assign w_ctl_req.hs   = (w_h_ext < H_SYNC_HI);
    assign w_ctl_req.vs   = (w_v_ext < V_SYNC_HI);
    assign w_ctl_req.act  = w_act;
    assign w_ctl_req.bord = w_bord;
    assign w_ctl_req.h0   = (r_cnt_h == '0);
    assign w_ctl_req.f0   = (r_cnt_h == '0) && (r_cnt_v == '0);

    // Control flags travel alongside the source's own REQ_LEAD-deep pipeline;
    // the reset flush guarantees no stale sync/pulse escapes after a reset.
    vga_delay_line #(
        .W     (DISP_CTL_W),
        .DEPTH (REQ_LEAD)
    ) u_disp_dly (
        .i_clk   (Clk_int),
        .i_clr_n (Sys_Rst_n),
        .i_dat   (w_ctl_req),
        .o_dat   (w_ctl_disp)
    );

    // Display stage: cleared pipeline maps to inactive syncs, de=0, Rgb=0
    assign H_sys       = w_ctl_disp.hs ? SYNC_POL : ~SYNC_POL;
    assign V_sys       = w_ctl_disp.vs ? SYNC_POL : ~SYNC_POL;
    assign de          = w_ctl_disp.act;
    assign line_start  = w_ctl_disp.h0;
    assign frame_start = w_ctl_disp.f0;
    assign Rgb         = w_ctl_disp.act  ? pix_colour   :
                         w_ctl_disp.bord ? BORDER_COLOR : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-reset bench for vga_timing_gen on a small raster with borders and active-low syncs.
// Latency: expectations are queued per clock edge and popped by an independent monitor.
// Backpressure: none; a stub source returns a salted colour of (x,y) REQ_LEAD clocks after each request.
module tb_vga_timing_gen;

    // Small raster: H 3/2/2/8/2/2 = 19, V 2/1/2/5/1/2 = 13, frame = 247 clocks
    localparam int H_SYNC = 3, H_BACK = 2, H_LEFT = 2, H_VALID = 8, H_RIGHT = 2, H_FRONT = 2;
    localparam int V_SYNC = 2, V_BACK = 1, V_TOP = 2, V_VALID = 5, V_BOTTOM = 1, V_FRONT = 2;
    localparam int HT = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
    localparam int CW = $clog2(HT > VT ? HT : VT);
    localparam int RL = 3;
    localparam logic POL = 1'b0;
    localparam logic [15:0] BORDER = 16'hF800;
    localparam int N_CYC = 6000;

    logic          Clk_int;
    logic          Sys_Rst_n;
    logic [15:0]   pix_colour;
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [15:0]   Rgb;
    logic          H_sys;
    logic          V_sys;
    logic          de;
    logic          line_start;
    logic          frame_start;

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_LEFT(H_LEFT), .H_VALID(H_VALID),
        .H_RIGHT(H_RIGHT), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOP(V_TOP), .V_VALID(V_VALID),
        .V_BOTTOM(V_BOTTOM), .V_FRONT(V_FRONT),
        .COLOR_W(16), .REQ_LEAD(RL), .SYNC_POL(POL), .BORDER_COLOR(BORDER)
    ) dut (
        .Clk_int     (Clk_int),
        .Sys_Rst_n   (Sys_Rst_n),
        .pix_colour  (pix_colour),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .Rgb         (Rgb),
        .H_sys       (H_sys),
        .V_sys       (V_sys),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    typedef struct {
        int req; int x; int y;
        int hs; int vs; int de; int rgb; int ls; int fs;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] src_q[$];
    logic [15:0] salt;
    int          checks = 0;
    int          failures = 0;
    int          mon_cyc = 0;

    initial Clk_int = 1'b0;
    always #5 Clk_int = ~Clk_int;

    // Picture content the stub source returns for pixel (x,y)
    function automatic logic [15:0] colour_of(input int x, input int y);
        logic [15:0] c;
        c = 16'(x * 37 + y * 211) ^ salt;
        return c;
    endfunction

    function automatic bit in_rect(input int h, input int v,
                                   input int h_lo, input int h_hi,
                                   input int v_lo, input int v_hi);
        return (h >= h_lo) && (h < h_hi) && (v >= v_lo) && (v < v_hi);
    endfunction

    // Reference: n clocks since the last reset edge puts the raster at linear position n
    function automatic exp_t model(input int n);
        exp_t e;
        int h, v, ph, pv, p;
        int ha0, va0;
        bit a, b;
        ha0 = H_SYNC + H_BACK + H_LEFT;
        va0 = V_SYNC + V_BACK + V_TOP;
        h = n % HT;
        v = (n / HT) % VT;
        a = in_rect(h, v, ha0, ha0 + H_VALID, va0, va0 + V_VALID);
        e.req = a;
        e.x   = a ? h - ha0 : 0;
        e.y   = a ? v - va0 : 0;
        if (n < RL) begin
            e.hs = !POL; e.vs = !POL; e.de = 0; e.rgb = 0; e.ls = 0; e.fs = 0;
        end else begin
            p  = n - RL;
            ph = p % HT;
            pv = (p / HT) % VT;
            a  = in_rect(ph, pv, ha0, ha0 + H_VALID, va0, va0 + V_VALID);
            b  = in_rect(ph, pv, H_SYNC + H_BACK, ha0 + H_VALID + H_RIGHT,
                         V_SYNC + V_BACK, va0 + V_VALID + V_BOTTOM) && !a;
            e.hs  = (ph < H_SYNC) ? POL : !POL;
            e.vs  = (pv < V_SYNC) ? POL : !POL;
            e.de  = a;
            e.rgb = a ? int'(colour_of(ph - ha0, pv - va0)) : (b ? int'(BORDER) : 0);
            e.ls  = (ph == 0);
            e.fs  = (ph == 0) && (pv == 0);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, mon_cyc, act, exp);
        end
    endtask

    // Stub source: capture the request address each clock, answer RL clocks later
    initial begin
        pix_colour = '0;
        forever begin
            @(negedge Clk_int);
            src_q.push_back(colour_of(int'(pix_x), int'(pix_y)));
            if (src_q.size() > RL) void'(src_q.pop_front());
            @(posedge Clk_int);
            #1;
            if (src_q.size() == RL) pix_colour = src_q[0];
        end
    end

    // Monitor: one expectation per clock edge, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk_int);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mon_cyc++;
                chk("pix_req",     32'(pix_req),     e.req);
                chk("pix_x",       32'(pix_x),       e.x);
                chk("pix_y",       32'(pix_y),       e.y);
                chk("H_sys",       32'(H_sys),       e.hs);
                chk("V_sys",       32'(V_sys),       e.vs);
                chk("de",          32'(de),          e.de);
                chk("Rgb",         32'(Rgb),         e.rgb);
                chk("line_start",  32'(line_start),  e.ls);
                chk("frame_start", 32'(frame_start), e.fs);
            end
        end
    end

    // Stimulus: random reset pulses of 1..3 clocks; expectation queued per edge
    initial begin
        int n, n_next, hold;
        logic rst_n;
        salt = 16'($urandom);
        n = 0;
        hold = 5;
        Sys_Rst_n = 1'b0;
        for (int c = 0; c < N_CYC; c++) begin
            if (hold > 0) begin
                rst_n = 1'b0;
                hold--;
            end else if ($urandom_range(0, 699) == 0) begin
                rst_n = 1'b0;
                hold = $urandom_range(0, 2);
            end else begin
                rst_n = 1'b1;
            end
            n_next = rst_n ? n + 1 : 0;
            exp_q.push_back(model(n_next));
            Sys_Rst_n = rst_n;
            @(posedge Clk_int);
            #1;
            n = n_next;
        end
        @(negedge Clk_int);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
